// File: rtl/occupancy_conditioner.sv
// occupancy_conditioner: turns a raw PIR input into the occupancy level P and a lux reading into the ambient-low level L.
// Latency: pir_raw reaches the FSM after a 2-flop synchroniser, and P is registered from the FSM next state; lux->L takes 1 clk.
// Backpressure: none. This is a free-running level conditioner and every input is consumed on each clk.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   pir_raw  raw motion sensor, asynchronous to clk
//   tick     1-clk timebase strobe that paces the hold timer
//   lux      ambient light reading, synchronous to clk
//   P        registered occupancy level (high in OCCUPIED and HOLD)
//   L        registered ambient-low level
//
// Build option: define AMBIENT_HYST_EN to give L the LUX_ON/LUX_OFF hysteresis.
// Without it, L is simply (lux < LUX_ON) and LUX_OFF is unused.
module occupancy_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD_CYC = 16,
  parameter int LUX_W    = 8,
  parameter int LUX_ON   = 64,
  parameter int LUX_OFF  = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pir_raw,
  input  logic             tick,
  input  logic [LUX_W-1:0] lux,
  output logic             P,
  output logic             L
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [DW-1:0]    DEB_ONE   = DW'(1);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYC);
  localparam logic [LUX_W-1:0] LUX_ON_C  = LUX_W'(LUX_ON);

  // Reject parameter sets the FSM and the threshold logic cannot honour.
  if (DEBOUNCE < 1 || HOLD_CYC < 1 || LUX_OFF <= LUX_ON) begin : g_bad_cfg
    $error("occupancy_conditioner: illegal DEBOUNCE/HOLD_CYC/LUX thresholds");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    OCCUPIED = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            sync1_q, s_q;
  logic            P_q, L_q, L_d;

  // Two-flop synchroniser. Only s_q may feed the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= pir_raw;
      s_q     <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_q) begin
          // A single-sample debounce accepts motion on the first high sample.
          if (DEBOUNCE == 1) begin
            state_d = OCCUPIED;
          end else begin
            state_d   = ARMING;
            deb_cnt_d = DEB_ONE;
          end
        end
      end
      ARMING: begin
        if (!s_q) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = OCCUPIED;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      OCCUPIED: begin
        if (!s_q) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        // A retrigger takes priority over a coincident tick, so no decrement happens on that edge.
        if (s_q) begin
          state_d = OCCUPIED;
        end else if (tick) begin
          if (hold_cnt_q == HOLD_ONE) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef AMBIENT_HYST_EN
    L_d = L_q;
    if (lux < LUX_ON_C) begin
      L_d = 1'b1;
    end else if (lux > LUX_W'(LUX_OFF)) begin
      L_d = 1'b0;
    end
`else
    L_d = (lux < LUX_ON_C);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      P_q        <= 1'b0;
      L_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      // Registering P from the next state keeps P glitch-free and aligned with the FSM.
      P_q        <= (state_d == OCCUPIED) || (state_d == HOLD);
      L_q        <= L_d;
    end
  end

  assign P = P_q;
  assign L = L_q;

endmodule

// File: tb/tb_occupancy_conditioner.sv
module tb_occupancy_conditioner;

  localparam int DEBOUNCE = 4;
  localparam int HOLD_CYC = 16;
  localparam int LUX_W    = 8;
  localparam int LUX_ON   = 64;
  localparam int LUX_OFF  = 96;

  logic             clk = 1'b0;
  logic             rst;
  logic             pir_raw;
  logic             tick;
  logic [LUX_W-1:0] lux;
  logic             P;
  logic             L;

  int n_chk = 0;
  int n_bad = 0;

  occupancy_conditioner #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD_CYC (HOLD_CYC),
    .LUX_W    (LUX_W),
    .LUX_ON   (LUX_ON),
    .LUX_OFF  (LUX_OFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pir_raw (pir_raw),
    .tick    (tick),
    .lux     (lux),
    .P       (P),
    .L       (L)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  // Behavioural reference.
  // Motion is accepted once DEBOUNCE consecutive synchronised samples are high.
  // After the first low sample, occupancy lasts HOLD_CYC more ticks, and any high sample restarts it.
  bit m_h0, m_h1;   // pir samples from 1 and 2 edges ago
  bit m_occ;        // expected P
  int m_run;        // consecutive high samples while not occupied
  int m_left;       // remaining ticks, -1 while motion is present
  bit m_l;          // expected L

  task automatic model_reset();
    m_h0 = 0; m_h1 = 0; m_occ = 0; m_run = 0; m_left = -1; m_l = 0;
  endtask

  task automatic model_edge(input bit pir, input bit tk, input int lx);
    bit s;
    s    = m_h1;
    m_h1 = m_h0;
    m_h0 = pir;
    if (s) begin
      if (m_occ) begin
        m_left = -1;
      end else begin
        m_run++;
        if (m_run >= DEBOUNCE) begin
          m_occ  = 1;
          m_left = -1;
          m_run  = 0;
        end
      end
    end else begin
      m_run = 0;
      if (m_occ) begin
        if (m_left < 0) begin
          m_left = HOLD_CYC;
        end else if (tk) begin
          m_left--;
          if (m_left == 0) m_occ = 0;
        end
      end
    end
`ifdef AMBIENT_HYST_EN
    if (lx < LUX_ON) m_l = 1;
    else if (lx > LUX_OFF) m_l = 0;
`else
    m_l = (lx < LUX_ON);
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, let the model advance on the rising edge, then compare.
  task automatic step(input bit pir, input bit tk, input int lx);
    @(negedge clk);
    pir_raw = pir;
    tick    = tk;
    lux     = LUX_W'(lx);
    @(posedge clk);
    model_edge(pir, tk, lx);
    #1;
    chk("P", P, m_occ);
    chk("L", L, m_l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_P", P, 0);
    chk("rst_L", L, 0);
    pir_raw = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int lat;
  int seen;
  int lv;
  int runlen;
  bit lvl;
  int lux_seq[5];
  int l_exp[5];

  initial begin
    rst = 1'b1; pir_raw = 1'b0; tick = 1'b0; lux = '0;
    model_reset();
    #1;
    chk("init_P", P, 0);
    chk("init_L", L, 0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Idle with pir low: P stays 0.
    for (int i = 0; i < 6; i++) step(0, 1, 120);

    // Rise latency from the first high sample, then fall latency with tick every clk.
    lat = -1;
    for (int i = 0; i < 50 && lat < 0; i++) begin
      step(1, 1, 120);
      if (P === 1'b1) lat = i;
    end
    chk("rise_lat", lat, DEBOUNCE + 1);
    for (int i = 0; i < 10; i++) step(1, 1, 120);
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      step(0, 1, 120);
      if (P === 1'b0) lat = i;
    end
    chk("fall_lat", lat, HOLD_CYC + 2);

    // Glitches shorter than DEBOUNCE never raise P.
    seen = 0;
    for (int len = 1; len < DEBOUNCE; len++) begin
      for (int i = 0; i < len; i++) begin step(1, 1, 120); if (P === 1'b1) seen = 1; end
      for (int i = 0; i < 6; i++)   begin step(0, 1, 120); if (P === 1'b1) seen = 1; end
    end
    chk("glitch_P", seen, 0);

    // Retrigger in HOLD at hold count 5.
    for (int i = 0; i < 10; i++) step(1, 1, 120);
    for (int i = 0; i < 40 && m_left != 5; i++) step(0, 1, 120);
    chk("hold_at_5", m_left, 5);
    seen = 0;
    lat  = -1;
    step(1, 1, 120);
    for (int i = 1; i < 60 && lat < 0; i++) begin
      step(0, 1, 120);
      if (P === 1'b0) lat = i;
      if (i < 4 && P !== 1'b1) seen = 1;
    end
    chk("retrig_keepP", seen, 0);
    chk("retrig_fall", lat, HOLD_CYC + 3);

    // Slow timebase: a tick every 4th clk stretches the hold to 16 ticks.
    for (int i = 0; i < 10; i++) step(1, 1, 120);
    lat = -1;
    for (int i = 0; i < 120 && lat < 0; i++) begin
      step(0, (i % 4) == 3, 120);
      if (P === 1'b0) lat = i;
    end
    chk("slow_tick_fall", lat, 4 * HOLD_CYC - 1);

    // Ambient sequence.
    lux_seq = '{100, 80, 50, 80, 100};
`ifdef AMBIENT_HYST_EN
    l_exp = '{0, 0, 1, 1, 0};
`else
    l_exp = '{0, 0, 1, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      step(0, 0, lux_seq[i]);
      chk("lux_seq", L, l_exp[i]);
    end
    // Threshold boundaries.
    step(0, 0, LUX_ON - 1);
    step(0, 0, LUX_ON);
    step(0, 0, LUX_OFF);
    step(0, 0, LUX_OFF + 1);
    step(0, 0, LUX_OFF);

    // Asynchronous reset in the middle of a run while P=1 and L=1.
    for (int i = 0; i < 8; i++) step(1, 0, 10);
    chk("pre_rst_P", P, 1);
    chk("pre_rst_L", L, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 80);

    // Randomised traffic, with occasional resets.
    lvl = 0;
    runlen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (runlen == 0) begin
        lvl    = ~lvl;
        runlen = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      end
      runlen--;
      case ($urandom_range(0, 3))
        0:       lv = $urandom_range(0, 255);
        1:       lv = $urandom_range(LUX_ON - 2, LUX_ON + 2);
        2:       lv = $urandom_range(LUX_OFF - 2, LUX_OFF + 2);
        default: lv = $urandom_range(LUX_ON, LUX_OFF);
      endcase
      step(lvl, $urandom_range(0, 2) == 0, lv);
      if ((c % 997) == 996) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
